// File: rtl/fb_bit_scanout.sv
// Read side of a 1-bit framebuffer: follows LCD timing, fetches the image window in raster
// order and emits RGB565 pixels with vs/hs/de realigned to the 2-cycle read latency.
module fb_bit_scanout #(
    parameter int          IMG_W  = 320,
    parameter int          IMG_H  = 256,
    parameter int          X_OFF  = 240,
    parameter int          Y_OFF  = 112,
    parameter int          ADDR_W = 17,
    parameter logic [15:0] FG     = 16'hFFFF,
    parameter logic [15:0] BG     = 16'h0000,
    parameter logic [15:0] BORDER = 16'h001F,
    parameter int          CNT_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vs_in,
    input  logic              hs_in,
    input  logic              de_in,
    output logic [ADDR_W-1:0] fb_adb,
    output logic              fb_ceb,
    output logic              fb_oce,
    input  logic              fb_dout,
    output logic [15:0]       rgb_out,
    output logic              vs_out,
    output logic              hs_out,
    output logic              de_out,
    output logic              frame_done
);

    typedef enum logic [0:0] {
        WAIT_VS = 1'b0,
        ACTIVE  = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [CNT_W-1:0]  X_LO      = CNT_W'(X_OFF);
    localparam logic [CNT_W-1:0]  X_HI      = CNT_W'(X_OFF + IMG_W - 1);
    localparam logic [CNT_W-1:0]  Y_LO      = CNT_W'(Y_OFF);
    localparam logic [CNT_W-1:0]  Y_HI      = CNT_W'(Y_OFF + IMG_H - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic              vs_q, de_q;
    logic [CNT_W-1:0]  x_cnt_q, x_cnt_d;
    logic [CNT_W-1:0]  y_cnt_q, y_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic              frame_done_q;
    logic              win_d1_q, vs_d1_q, hs_d1_q, de_d1_q;
    logic [15:0]       rgb_q;
    logic              vs_out_q, hs_out_q, de_out_q;

    logic              vs_rise_s, de_fall_s, in_win_s, rd_s, last_rd_s;

    // Edge detection, window decode and next-state for the raster counters
    always_comb begin
        vs_rise_s = vs_in & ~vs_q;
        de_fall_s = ~de_in & de_q;
        in_win_s  = de_in
                    && (x_cnt_q >= X_LO) && (x_cnt_q <= X_HI)
                    && (y_cnt_q >= Y_LO) && (y_cnt_q <= Y_HI);
        rd_s      = in_win_s && (state_q == ACTIVE);
        // done_q keeps a saturated address from reporting the frame end twice
        last_rd_s = rd_s && (addr_q == LAST_ADDR) && !done_q;

        state_d = state_q;
        x_cnt_d = x_cnt_q;
        y_cnt_d = y_cnt_q;
        addr_d  = addr_q;
        done_d  = done_q;

        case (state_q)
            WAIT_VS: begin
                if (vs_rise_s) begin
                    state_d = ACTIVE;
                    x_cnt_d = {CNT_W{1'b0}};
                    y_cnt_d = {CNT_W{1'b0}};
                    addr_d  = {ADDR_W{1'b0}};
                    done_d  = 1'b0;
                end else begin
                    state_d = WAIT_VS;
                end
            end
            ACTIVE: begin
                state_d = ACTIVE;
                if (vs_rise_s) begin
                    x_cnt_d = {CNT_W{1'b0}};
                    y_cnt_d = {CNT_W{1'b0}};
                    addr_d  = {ADDR_W{1'b0}};
                    done_d  = 1'b0;
                end else begin
                    if (de_fall_s) begin
                        x_cnt_d = {CNT_W{1'b0}};
                    end else if (de_in && (x_cnt_q != CNT_MAX)) begin
                        x_cnt_d = x_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        x_cnt_d = x_cnt_q;
                    end

                    if (de_fall_s && (y_cnt_q != CNT_MAX)) begin
                        y_cnt_d = y_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        y_cnt_d = y_cnt_q;
                    end

                    if (rd_s && (addr_q != LAST_ADDR)) begin
                        addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end else begin
                        addr_d = addr_q;
                    end

                    if (last_rd_s) begin
                        done_d = 1'b1;
                    end else begin
                        done_d = done_q;
                    end
                end
            end
            default: begin
                state_d = WAIT_VS;
            end
        endcase
    end

    // Sync state, edge-detect history and raster/address counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_VS;
            vs_q         <= 1'b0;
            de_q         <= 1'b0;
            x_cnt_q      <= {CNT_W{1'b0}};
            y_cnt_q      <= {CNT_W{1'b0}};
            addr_q       <= {ADDR_W{1'b0}};
            done_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_q         <= vs_in;
            de_q         <= de_in;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            addr_q       <= addr_d;
            done_q       <= done_d;
            frame_done_q <= last_rd_s;
        end
    end

    // Two-stage output pipeline matching the registered RAM read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_d1_q <= 1'b0;
            vs_d1_q  <= 1'b0;
            hs_d1_q  <= 1'b0;
            de_d1_q  <= 1'b0;
            rgb_q    <= 16'h0000;
            vs_out_q <= 1'b0;
            hs_out_q <= 1'b0;
            de_out_q <= 1'b0;
        end else begin
            win_d1_q <= rd_s;
            vs_d1_q  <= vs_in;
            hs_d1_q  <= hs_in;
            de_d1_q  <= de_in & (state_q == ACTIVE);
            rgb_q    <= win_d1_q ? (fb_dout ? FG : BG) : BORDER;
            vs_out_q <= vs_d1_q;
            hs_out_q <= hs_d1_q;
            de_out_q <= de_d1_q;
        end
    end

    assign fb_ceb     = rd_s;
    assign fb_adb     = addr_q;
    assign fb_oce     = 1'b1;
    assign rgb_out    = rgb_q;
    assign vs_out     = vs_out_q;
    assign hs_out     = hs_out_q;
    assign de_out     = de_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fb_bit_scanout.sv
// Directed bench for fb_bit_scanout on a reduced 40x14 panel with a 16x6 image window at (10,4).
module tb_fb_bit_scanout;

    localparam int          IMG_W  = 16;
    localparam int          IMG_H  = 6;
    localparam int          X_OFF  = 10;
    localparam int          Y_OFF  = 4;
    localparam int          PW     = 40;
    localparam int          PH     = 14;
    localparam logic [15:0] BORDER = 16'h001F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vs_in, hs_in, de_in;
    logic [16:0] fb_adb;
    logic        fb_ceb, fb_oce;
    logic        fb_dout = 1'b0;
    logic [15:0] rgb_out;
    logic        vs_out, hs_out, de_out, frame_done;

    int vec_cnt = 0;
    int err_cnt = 0;

    int          ceb_cnt, done_cnt, deo_cnt, nb_cnt, cyc;
    logic [16:0] first_adb, last_adb;
    int          first_x, first_y, last_rd_cyc, done_cyc;
    int          cur_x, cur_y;
    int          h1_x, h1_y, h2_x, h2_y;
    logic        h1_de, h2_de;
    int          cap_y0 = -1;
    int          cap_y1 = -1;
    logic [15:0] cap0 [0:PW-1];
    logic [15:0] cap1 [0:PW-1];
    logic        cap0_de [0:PW-1];

    always #5 clk = ~clk;

    fb_bit_scanout #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .X_OFF (X_OFF),
        .Y_OFF (Y_OFF),
        .ADDR_W(17)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vs_in     (vs_in),
        .hs_in     (hs_in),
        .de_in     (de_in),
        .fb_adb    (fb_adb),
        .fb_ceb    (fb_ceb),
        .fb_oce    (fb_oce),
        .fb_dout   (fb_dout),
        .rgb_out   (rgb_out),
        .vs_out    (vs_out),
        .hs_out    (hs_out),
        .de_out    (de_out),
        .frame_done(frame_done)
    );

    // Framebuffer model: stored bit equals address bit 0, one cycle read latency
    always @(posedge clk) begin
        if (fb_ceb) fb_dout <= fb_adb[0];
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_stats();
        ceb_cnt = 0; done_cnt = 0; deo_cnt = 0; nb_cnt = 0;
        last_rd_cyc = -1; done_cyc = -1; first_x = -1; first_y = -1;
        first_adb = '0; last_adb = '0;
    endtask

    // One pixel clock: drive at the falling edge, observe 1 ns later
    task automatic tick(input logic v, input logic h, input logic d);
        @(negedge clk);
        vs_in = v; hs_in = h; de_in = d;
        #1;
        if (fb_ceb) begin
            if (ceb_cnt == 0) begin
                first_adb = fb_adb; first_x = cur_x; first_y = cur_y;
            end
            last_adb = fb_adb; last_rd_cyc = cyc; ceb_cnt++;
        end
        if (frame_done) begin done_cnt++; done_cyc = cyc; end
        if (de_out) deo_cnt++;
        if (rgb_out !== BORDER) nb_cnt++;
        if (h2_de && h2_x < PW && h2_y == cap_y0) begin
            cap0[h2_x] = rgb_out; cap0_de[h2_x] = de_out;
        end
        if (h2_de && h2_x < PW && h2_y == cap_y1) cap1[h2_x] = rgb_out;
        h2_x = h1_x; h2_y = h1_y; h2_de = h1_de;
        h1_x = cur_x; h1_y = cur_y; h1_de = d;
        cyc++;
    endtask

    task automatic blank();
        tick(1'b0, 1'b1, 1'b0); tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic line(input int y, input int n);
        for (int c = 0; c < n; c++) begin
            cur_x = c; cur_y = y; tick(1'b0, 1'b0, 1'b1);
        end
        blank();
    endtask

    task automatic vs_pulse();
        tick(1'b1, 1'b0, 1'b0); tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame();
        vs_pulse();
        for (int y = 0; y < PH; y++) line(y, PW);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0;
        cyc = 0; h1_de = 1'b0; h2_de = 1'b0; cur_x = 0; cur_y = 0;
        h1_x = 0; h1_y = 0; h2_x = 0; h2_y = 0;
        repeat (3) @(negedge clk);
        #1;
        vec_cnt++;
        if ({fb_ceb, fb_adb, rgb_out, vs_out, hs_out, de_out, frame_done} !== 40'h0) begin
            err_cnt++;
            $display("FAIL reset_outputs: ceb=%b adb=%0d rgb=%h vs=%b hs=%b de=%b done=%b, expected all 0",
                     fb_ceb, fb_adb, rgb_out, vs_out, hs_out, de_out, frame_done);
        end
        vec_cnt++;
        if (fb_oce !== 1'b1) begin
            err_cnt++; $display("FAIL oce_tied: got %b expected 1", fb_oce);
        end
        rst_n = 1'b1;
        repeat (3) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_no_vs();
        clear_stats();
        tick(1'b0, 1'b1, 1'b0); tick(1'b0, 1'b0, 1'b0);
        vec_cnt++;
        if (hs_out !== 1'b0) begin err_cnt++; $display("FAIL hs_delay1: got %b expected 0", hs_out); end
        tick(1'b0, 1'b0, 1'b0);
        vec_cnt++;
        if (hs_out !== 1'b1) begin err_cnt++; $display("FAIL hs_delay2: got %b expected 1", hs_out); end
        for (int y = 0; y < 8; y++) line(y, PW);
        vec_cnt++;
        if (ceb_cnt != 0) begin err_cnt++; $display("FAIL novs_reads: got %0d expected 0", ceb_cnt); end
        vec_cnt++;
        if (deo_cnt != 0) begin err_cnt++; $display("FAIL novs_de_out: got %0d high cycles expected 0", deo_cnt); end
        vec_cnt++;
        if (nb_cnt != 0) begin err_cnt++; $display("FAIL novs_rgb: got %0d non-border cycles expected 0", nb_cnt); end
    endtask

    task automatic test_frame();
        clear_stats();
        tick(1'b1, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0);
        vec_cnt++;
        if (vs_out !== 1'b0) begin err_cnt++; $display("FAIL vs_delay1: got %b expected 0", vs_out); end
        tick(1'b0, 1'b0, 1'b0);
        vec_cnt++;
        if (vs_out !== 1'b1) begin err_cnt++; $display("FAIL vs_delay2: got %b expected 1", vs_out); end
        for (int y = 0; y < PH; y++) line(y, PW);
        vec_cnt++;
        if (ceb_cnt != 96) begin err_cnt++; $display("FAIL frame_reads: got %0d expected 96", ceb_cnt); end
        vec_cnt++;
        if (first_adb !== 17'd0 || first_x != 10 || first_y != 4) begin
            err_cnt++;
            $display("FAIL first_read: adb=%0d at (%0d,%0d) expected adb=0 at (10,4)", first_adb, first_x, first_y);
        end
        vec_cnt++;
        if (last_adb !== 17'd95) begin err_cnt++; $display("FAIL last_adb: got %0d expected 95", last_adb); end
        vec_cnt++;
        if (done_cnt != 1 || done_cyc != last_rd_cyc + 1) begin
            err_cnt++;
            $display("FAIL frame_done: got %0d pulses at cycle %0d expected 1 pulse at %0d",
                     done_cnt, done_cyc, last_rd_cyc + 1);
        end
    endtask

    task automatic test_pixels();
        logic [15:0] exp_c;
        cap_y0 = 4; cap_y1 = 9;
        frame();
        cap_y0 = -1; cap_y1 = -1;
        for (int c = X_OFF; c < X_OFF + IMG_W; c++) begin
            exp_c = (((c - X_OFF) % 2) == 1) ? 16'hFFFF : 16'h0000;
            vec_cnt++;
            if (cap0[c] !== exp_c || cap0_de[c] !== 1'b1) begin
                err_cnt++;
                $display("FAIL pixel_alt col %0d: rgb=%h de=%b expected rgb=%h de=1", c, cap0[c], cap0_de[c], exp_c);
            end
        end
        vec_cnt++;
        if (cap0[9] !== BORDER) begin err_cnt++; $display("FAIL pix_9_4: got %h expected 001f", cap0[9]); end
        vec_cnt++;
        if (cap0[10] !== 16'h0000) begin err_cnt++; $display("FAIL pix_10_4: got %h expected 0000", cap0[10]); end
        vec_cnt++;
        if (cap1[10] !== 16'h0000) begin err_cnt++; $display("FAIL pix_10_9: got %h expected 0000", cap1[10]); end
        vec_cnt++;
        if (cap1[25] !== 16'hFFFF) begin err_cnt++; $display("FAIL pix_25_9: got %h expected ffff", cap1[25]); end
        vec_cnt++;
        if (cap1[26] !== BORDER) begin err_cnt++; $display("FAIL pix_26_9: got %h expected 001f", cap1[26]); end
    endtask

    task automatic test_reset_mid_line();
        vs_pulse();
        for (int y = 0; y < 7; y++) line(y, PW);
        for (int c = 0; c <= 30; c++) begin cur_x = c; cur_y = 7; tick(1'b0, 1'b0, 1'b1); end
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({fb_ceb, fb_adb, rgb_out, vs_out, hs_out, de_out, frame_done} !== 40'h0) begin
            err_cnt++;
            $display("FAIL async_reset: ceb=%b adb=%0d rgb=%h de=%b done=%b, expected all 0",
                     fb_ceb, fb_adb, rgb_out, de_out, frame_done);
        end
        tick(1'b0, 1'b0, 1'b1); tick(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0);
        clear_stats();
        for (int y = 0; y < PH; y++) line(y, PW);
        vec_cnt++;
        if (ceb_cnt != 0 || deo_cnt != 0) begin
            err_cnt++;
            $display("FAIL post_reset_idle: reads=%0d de_out=%0d expected 0 and 0", ceb_cnt, deo_cnt);
        end
        clear_stats();
        frame();
        vec_cnt++;
        if (ceb_cnt != 96 || first_adb !== 17'd0 || done_cnt != 1) begin
            err_cnt++;
            $display("FAIL post_reset_frame: reads=%0d first=%0d done=%0d expected 96 0 1", ceb_cnt, first_adb, done_cnt);
        end
    endtask

    task automatic test_vs_restart();
        clear_stats();
        vs_pulse();
        for (int y = 0; y < 7; y++) line(y, PW);
        for (int c = 0; c <= 15; c++) begin
            cur_x = c; cur_y = 7; tick((c == 15) ? 1'b1 : 1'b0, 1'b0, 1'b1);
        end
        vec_cnt++;
        if (ceb_cnt != 54 || last_adb !== 17'd53 || done_cnt != 0) begin
            err_cnt++;
            $display("FAIL truncated_frame: reads=%0d last=%0d done=%0d expected 54 53 0", ceb_cnt, last_adb, done_cnt);
        end
        clear_stats();
        cur_x = 16; cur_y = 0; tick(1'b1, 1'b0, 1'b1);
        for (int c = 17; c < PW; c++) begin cur_x = c; cur_y = 0; tick(1'b0, 1'b0, 1'b1); end
        blank();
        for (int y = 1; y < PH; y++) line(y, PW);
        vec_cnt++;
        if (ceb_cnt != 96 || first_adb !== 17'd0 || first_y != 4 || first_x != 10) begin
            err_cnt++;
            $display("FAIL restart_frame: reads=%0d first adb=%0d at (%0d,%0d) expected 96 0 at (10,4)",
                     ceb_cnt, first_adb, first_x, first_y);
        end
        vec_cnt++;
        if (done_cnt != 1) begin err_cnt++; $display("FAIL restart_done: got %0d pulses expected 1", done_cnt); end
    endtask

    task automatic test_x_saturate();
        clear_stats();
        vs_pulse();
        for (int y = 0; y < 4; y++) line(y, PW);
        line(4, 4200);
        vec_cnt++;
        if (ceb_cnt != 16 || last_adb !== 17'd15) begin
            err_cnt++;
            $display("FAIL x_saturate: reads=%0d last=%0d expected 16 15", ceb_cnt, last_adb);
        end
    endtask

    initial begin
        test_reset();
        test_no_vs();
        test_frame();
        test_pixels();
        test_reset_mid_line();
        test_vs_restart();
        test_x_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
